// File: rtl/id_return_tracker.sv
//------------------------------------------------------------------------------
// Module   : id_return_tracker
// Brief    : Tags requests with pool IDs, holds per-ID metadata, completes on
//            response and returns the ID to the pool. Optional build macro
//            ID_RETURN_TRACKER_TIMEOUT_EN adds per-ID age / timeout detection.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_return_tracker #(
    parameter int ID_W    = 3,
    parameter int META_W  = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_alloc_valid,
    input  logic [ID_W-1:0]      io_alloc_bits,
    output logic                 io_alloc_ready,
    input  logic                 io_req_valid,
    input  logic [META_W-1:0]    io_req_meta,
    output logic                 io_req_ready,
    output logic                 io_issue_valid,
    output logic [ID_W-1:0]      io_issue_id,
    output logic [META_W-1:0]    io_issue_meta,
    input  logic                 io_issue_ready,
    input  logic                 io_resp_valid,
    input  logic [ID_W-1:0]      io_resp_id,
    output logic                 io_done_valid,
    output logic [ID_W-1:0]      io_done_id,
    output logic [META_W-1:0]    io_done_meta,
    output logic                 io_free_valid,
    output logic [ID_W-1:0]      io_free_bits,
    output logic [2**ID_W-1:0]   io_busy,
    output logic                 io_err,
    output logic                 io_timeout,
    output logic [ID_W-1:0]      io_timeout_id
);

    localparam int NUM_IDS = 2**ID_W;

    logic                r_issue_valid;
    logic [ID_W-1:0]     r_issue_id;
    logic [META_W-1:0]   r_issue_meta;
    logic [META_W-1:0]   r_meta_table [NUM_IDS];
    logic [NUM_IDS-1:0]  r_busy;
    logic                r_done_valid;
    logic [ID_W-1:0]     r_done_id;
    logic [META_W-1:0]   r_done_meta;
    logic                r_err;

    logic                w_slot_open;
    logic                w_fire;
    logic                w_resp_hit;
    logic [NUM_IDS-1:0]  w_busy_set;
    logic [NUM_IDS-1:0]  w_busy_clr;

    assign w_slot_open    = ~r_issue_valid | io_issue_ready;
    assign w_fire         = io_req_valid & io_alloc_valid & w_slot_open;
    assign io_req_ready   = io_alloc_valid & w_slot_open;
    assign io_alloc_ready = io_req_valid & w_slot_open;

    // Hit test uses the pre-update bitmap, so an ID fired this cycle is not yet in flight.
    assign w_resp_hit = io_resp_valid & r_busy[io_resp_id];
    assign w_busy_set = w_fire     ? (NUM_IDS'(1) << io_alloc_bits) : '0;
    assign w_busy_clr = w_resp_hit ? (NUM_IDS'(1) << io_resp_id)    : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_issue_valid <= 1'b0;
            r_issue_id    <= '0;
            r_issue_meta  <= '0;
        end else if (w_fire) begin
            r_issue_valid <= 1'b1;
            r_issue_id    <= io_alloc_bits;
            r_issue_meta  <= io_req_meta;
        end else if (io_issue_ready) begin
            r_issue_valid <= 1'b0;
        end
    end

    // Metadata storage is only meaningful while the busy bit is set; no reset needed.
    always_ff @(posedge clock) begin
        if (w_fire) begin
            r_meta_table[io_alloc_bits] <= io_req_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy       <= '0;
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
            r_done_meta  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_busy       <= (r_busy & ~w_busy_clr) | w_busy_set;
            r_done_valid <= w_resp_hit;
            if (w_resp_hit) begin
                r_done_id   <= io_resp_id;
                r_done_meta <= r_meta_table[io_resp_id];
            end
            r_err <= r_err | (io_resp_valid & ~r_busy[io_resp_id]);
        end
    end

    assign io_issue_valid = r_issue_valid;
    assign io_issue_id    = r_issue_id;
    assign io_issue_meta  = r_issue_meta;
    assign io_done_valid  = r_done_valid;
    assign io_done_id     = r_done_id;
    assign io_done_meta   = r_done_meta;
    assign io_free_valid  = r_done_valid;
    assign io_free_bits   = r_done_id;
    assign io_busy        = r_busy;
    assign io_err         = r_err;

`ifdef ID_RETURN_TRACKER_TIMEOUT_EN
    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    logic [15:0]         r_age [NUM_IDS];
    logic                r_timeout;
    logic [ID_W-1:0]     r_timeout_id;
    logic                w_to_hit;
    logic [ID_W-1:0]     w_to_id;

    // Age restarts on allocation and is parked at zero while the ID is idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                if (w_busy_set[i]) begin
                    r_age[i] <= '0;
                end else if (r_busy[i]) begin
                    if (r_age[i] < c_timeout) begin
                        r_age[i] <= r_age[i] + 16'd1;
                    end
                end else begin
                    r_age[i] <= '0;
                end
            end
        end
    end

    // Descending scan so the lowest expired ID is the one left standing.
    always_comb begin
        w_to_hit = 1'b0;
        w_to_id  = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (r_busy[i] && (r_age[i] == c_timeout)) begin
                w_to_hit = 1'b1;
                w_to_id  = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else if (w_to_hit && !r_timeout) begin
            r_timeout    <= 1'b1;
            r_timeout_id <= w_to_id;
        end
    end

    assign io_timeout    = r_timeout;
    assign io_timeout_id = r_timeout_id;
`else
    logic [15:0] w_timeout_unused;

    assign w_timeout_unused = 16'(TIMEOUT);
    assign io_timeout       = 1'b0;
    assign io_timeout_id    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_return_tracker.sv
//------------------------------------------------------------------------------
// Module   : tb_id_return_tracker
// Brief    : Directed vector table plus hand sequences for id_return_tracker.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_return_tracker;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_alloc_valid = 1'b0;
    logic [2:0] io_alloc_bits = '0;
    logic       io_alloc_ready;
    logic       io_req_valid = 1'b0;
    logic [7:0] io_req_meta = '0;
    logic       io_req_ready;
    logic       io_issue_valid;
    logic [2:0] io_issue_id;
    logic [7:0] io_issue_meta;
    logic       io_issue_ready = 1'b0;
    logic       io_resp_valid = 1'b0;
    logic [2:0] io_resp_id = '0;
    logic       io_done_valid;
    logic [2:0] io_done_id;
    logic [7:0] io_done_meta;
    logic       io_free_valid;
    logic [2:0] io_free_bits;
    logic [7:0] io_busy;
    logic       io_err;
    logic       io_timeout;
    logic [2:0] io_timeout_id;

    int checks   = 0;
    int failures = 0;

    id_return_tracker #(.ID_W(3), .META_W(8), .TIMEOUT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_alloc_valid (io_alloc_valid),
        .io_alloc_bits  (io_alloc_bits),
        .io_alloc_ready (io_alloc_ready),
        .io_req_valid   (io_req_valid),
        .io_req_meta    (io_req_meta),
        .io_req_ready   (io_req_ready),
        .io_issue_valid (io_issue_valid),
        .io_issue_id    (io_issue_id),
        .io_issue_meta  (io_issue_meta),
        .io_issue_ready (io_issue_ready),
        .io_resp_valid  (io_resp_valid),
        .io_resp_id     (io_resp_id),
        .io_done_valid  (io_done_valid),
        .io_done_id     (io_done_id),
        .io_done_meta   (io_done_meta),
        .io_free_valid  (io_free_valid),
        .io_free_bits   (io_free_bits),
        .io_busy        (io_busy),
        .io_err         (io_err),
        .io_timeout     (io_timeout),
        .io_timeout_id  (io_timeout_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       av;  logic [2:0] ab;
        logic       rv;  logic [7:0] rm;
        logic       ir;
        logic       sv;  logic [2:0] sid;
        logic       x_rr; logic x_ar;
        logic       x_iv; logic [2:0] x_iid; logic [7:0] x_im;
        logic       x_dv; logic [2:0] x_did; logic [7:0] x_dm;
        logic [7:0] x_busy;
        logic       x_err;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(logic av, logic [2:0] ab, logic rv, logic [7:0] rm,
                                logic ir, logic sv, logic [2:0] sid,
                                logic x_rr, logic x_ar,
                                logic x_iv, logic [2:0] x_iid, logic [7:0] x_im,
                                logic x_dv, logic [2:0] x_did, logic [7:0] x_dm,
                                logic [7:0] x_busy, logic x_err);
        vec_t v;
        v.av = av; v.ab = ab; v.rv = rv; v.rm = rm; v.ir = ir; v.sv = sv; v.sid = sid;
        v.x_rr = x_rr; v.x_ar = x_ar;
        v.x_iv = x_iv; v.x_iid = x_iid; v.x_im = x_im;
        v.x_dv = x_dv; v.x_did = x_did; v.x_dm = x_dm;
        v.x_busy = x_busy; v.x_err = x_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] ab, input logic rv, input logic [7:0] rm,
                         input logic ir, input logic sv, input logic [2:0] sid);
        io_alloc_valid = av; io_alloc_bits = ab;
        io_req_valid   = rv; io_req_meta   = rm;
        io_issue_ready = ir;
        io_resp_valid  = sv; io_resp_id    = sid;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_issue_valid"}, {31'd0, io_issue_valid}, 32'd0);
        chk({tag, "_done_valid"},  {31'd0, io_done_valid},  32'd0);
        chk({tag, "_free_valid"},  {31'd0, io_free_valid},  32'd0);
        chk({tag, "_busy"},        {24'd0, io_busy},        32'd0);
        chk({tag, "_err"},         {31'd0, io_err},         32'd0);
        chk({tag, "_timeout"},     {31'd0, io_timeout},     32'd0);
        chk({tag, "_req_ready"},   {31'd0, io_req_ready},   32'd0);
        chk({tag, "_alloc_ready"}, {31'd0, io_alloc_ready}, 32'd0);
    endtask

    initial begin
        int n;

        // av ab rv rm ir sv sid | rr ar | iv iid im | dv did dm | busy err
        vecs[0]  = mk(1,0,1,8'h5A,1,0,0, 1,1, 1,0,8'h5A, 0,0,8'h00, 8'h01,0);
        vecs[1]  = mk(1,1,0,8'h00,1,1,0, 1,0, 0,0,8'h00, 1,0,8'h5A, 8'h00,0);
        vecs[2]  = mk(1,1,1,8'h11,0,0,0, 1,1, 1,1,8'h11, 0,0,8'h00, 8'h02,0);
        vecs[3]  = mk(1,2,1,8'h22,0,0,0, 0,0, 1,1,8'h11, 0,0,8'h00, 8'h02,0);
        vecs[4]  = mk(1,2,1,8'h22,1,0,0, 1,1, 1,2,8'h22, 0,0,8'h00, 8'h06,0);
        vecs[5]  = mk(0,0,0,8'h00,1,1,1, 0,0, 0,0,8'h00, 1,1,8'h11, 8'h04,0);
        vecs[6]  = mk(0,0,0,8'h00,1,1,2, 0,0, 0,0,8'h00, 1,2,8'h22, 8'h00,0);
        for (int k = 0; k < 8; k++) begin
            vecs[7+k] = mk(1, 3'(k), 1, 8'(k), 1, 0, 0, 1, 1, 1, 3'(k), 8'(k),
                           0, 0, 8'h00, 8'((16'd1 << (k + 1)) - 16'd1), 0);
        end
        vecs[15] = mk(0,0,0,8'h00,1,1,7, 0,0, 0,0,8'h00, 1,7,8'h07, 8'h7F,0);
        vecs[16] = mk(0,0,0,8'h00,1,1,3, 0,0, 0,0,8'h00, 1,3,8'h03, 8'h77,0);
        vecs[17] = mk(0,0,0,8'h00,1,1,0, 0,0, 0,0,8'h00, 1,0,8'h00, 8'h76,0);

        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        reset = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].av, vecs[i].ab, vecs[i].rv, vecs[i].rm, vecs[i].ir, vecs[i].sv, vecs[i].sid);
            #1;
            chk($sformatf("v%0d_req_ready", i),   {31'd0, io_req_ready},   {31'd0, vecs[i].x_rr});
            chk($sformatf("v%0d_alloc_ready", i), {31'd0, io_alloc_ready}, {31'd0, vecs[i].x_ar});
            tick();
            chk($sformatf("v%0d_issue_valid", i), {31'd0, io_issue_valid}, {31'd0, vecs[i].x_iv});
            if (vecs[i].x_iv) begin
                chk($sformatf("v%0d_issue_id", i),   {29'd0, io_issue_id},   {29'd0, vecs[i].x_iid});
                chk($sformatf("v%0d_issue_meta", i), {24'd0, io_issue_meta}, {24'd0, vecs[i].x_im});
            end
            chk($sformatf("v%0d_done_valid", i), {31'd0, io_done_valid}, {31'd0, vecs[i].x_dv});
            chk($sformatf("v%0d_free_valid", i), {31'd0, io_free_valid}, {31'd0, vecs[i].x_dv});
            if (vecs[i].x_dv) begin
                chk($sformatf("v%0d_done_id", i),   {29'd0, io_done_id},   {29'd0, vecs[i].x_did});
                chk($sformatf("v%0d_free_bits", i), {29'd0, io_free_bits}, {29'd0, vecs[i].x_did});
                chk($sformatf("v%0d_done_meta", i), {24'd0, io_done_meta}, {24'd0, vecs[i].x_dm});
            end
            chk($sformatf("v%0d_busy", i), {24'd0, io_busy}, {24'd0, vecs[i].x_busy});
            chk($sformatf("v%0d_err", i),  {31'd0, io_err},  {31'd0, vecs[i].x_err});
        end

        // Fire and response for the same ID in one cycle.
        do_reset();
        drive(1'b1, 3'd2, 1'b1, 8'h44, 1'b1, 1'b1, 3'd2);
        tick();
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
        chk("coll_err",        {31'd0, io_err},        32'd1);
        chk("coll_busy",       {24'd0, io_busy},       32'h04);
        chk("coll_free_valid", {31'd0, io_free_valid}, 32'd0);
        chk("coll_done_valid", {31'd0, io_done_valid}, 32'd0);
        chk("coll_issue_id",   {29'd0, io_issue_id},   32'd2);

        // Response for an idle ID, then stickiness.
        do_reset();
        chk("err_pre", {31'd0, io_err}, 32'd0);
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd5);
        tick();
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
        chk("err_set",        {31'd0, io_err},        32'd1);
        chk("err_done_valid", {31'd0, io_done_valid}, 32'd0);
        chk("err_free_valid", {31'd0, io_free_valid}, 32'd0);
        chk("err_busy",       {24'd0, io_busy},       32'd0);
        repeat (10) tick();
        chk("err_sticky",     {31'd0, io_err},        32'd1);

        // Long-lived ID 3 with no response.
        do_reset();
        drive(1'b1, 3'd3, 1'b1, 8'h33, 1'b1, 1'b0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
        chk("to_busy", {24'd0, io_busy}, 32'h08);
`ifdef ID_RETURN_TRACKER_TIMEOUT_EN
        n = 0;
        while (!io_timeout && n < 20) begin
            tick();
            n++;
        end
        chk("to_latency", n, 32'd5);
        chk("to_flag",    {31'd0, io_timeout},    32'd1);
        chk("to_id",      {29'd0, io_timeout_id}, 32'd3);
`else
        n = 0;
        repeat (10) tick();
        chk("to_flag_off", {31'd0, io_timeout},    32'd0);
        chk("to_id_off",   {29'd0, io_timeout_id}, 32'd0);
`endif

        // Asynchronous reset between edges.
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("areset");
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_busy", {24'd0, io_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
